// File: rtl/list_walk_engine.sv
// Linked-list walk engine: follows value/next node pairs from head, reducing values (sum or max).
// Optional macro LIST_WALK_SAT_EN makes the mode-0 sum saturate instead of wrap.
module list_walk_engine #(
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int MAX_NODES = 64,
  parameter int CW        = $clog2(MAX_NODES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] head,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {IDLE, RD_VAL, ACC, NXT, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] result_q, result_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [DW:0]   sum_w;
  logic [DW-1:0] sum_v, max_v;

  assign sum_w = {1'b0, result_q} + {1'b0, mem_rdata};
`ifdef LIST_WALK_SAT_EN
  assign sum_v = sum_w[DW] ? {DW{1'b1}} : sum_w[DW-1:0];
`else
  assign sum_v = sum_w[DW-1:0];
`endif
  assign max_v = (mem_rdata > result_q) ? mem_rdata : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    result_d = result_q;
    count_d  = count_q;
    err_d    = err_q;
    mem_addr = '0;
    mem_rd   = 1'b0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          ptr_d    = head;
          result_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
          state_d  = (head == '0) ? FIN : RD_VAL;
        end
      end
      RD_VAL: begin
        mem_addr = ptr_q;
        mem_rd   = 1'b1;
        state_d  = ACC;
      end
      ACC: begin
        result_d = mode_q ? max_v : sum_v;
        count_d  = count_q + CW'(1);
        // next-pointer word sits right after the value; wraps at 2^AW
        mem_addr = ptr_q + AW'(1);
        mem_rd   = 1'b1;
        state_d  = NXT;
      end
      NXT: begin
        ptr_d = mem_rdata[AW-1:0];
        if (ptr_d == '0) begin
          state_d = FIN;
        end else if (count_q == CW'(MAX_NODES)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = RD_VAL;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;
  assign count  = count_q;
  assign err    = err_q;

endmodule

// File: tb/tb_list_walk_engine.sv
// Directed, table-driven bench for list_walk_engine (MAX_NODES=4) with a synchronous-read memory model.
module tb_list_walk_engine;
  localparam int DW = 16, AW = 8, MN = 4, CW = $clog2(MN + 1);

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [AW-1:0] head, mem_addr;
  logic          mem_rd, busy, done, err;
  logic [DW-1:0] mem_rdata, result;
  logic [CW-1:0] count;
  logic [DW-1:0] mem [256];

  int n_chk = 0, n_fail = 0;

  list_walk_engine #(.DW(DW), .AW(AW), .MAX_NODES(MN)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .head(head),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .result(result), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [AW-1:0] head;
    logic          mode;
    int            cyc;
    logic [DW-1:0] res;
    int            cnt;
    logic          err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start, then sample once per cycle; cycle 1 is the first cycle after acceptance.
  task automatic walk(input logic [AW-1:0] h, input logic m, output int cyc, output bit rd_seen,
                      output bit addr_bad);
    cyc = 0; rd_seen = 0; addr_bad = 0;
    start = 1'b1; head = h; mode = m;
    tick();
    start = 1'b0; head = 8'hEE; mode = ~m;
    for (int k = 1; k <= 200; k++) begin
      if (mem_rd) rd_seen = 1;
      if (!mem_rd && mem_addr != '0) addr_bad = 1;
      if (done) begin cyc = k; break; end
      if (!busy) addr_bad = 1;
      tick();
    end
  endtask

  initial begin
    int   cyc, pulses;
    bit   rd_seen, addr_bad;
    logic [DW-1:0] exp_ovf;

    foreach (mem[i]) mem[i] = '0;
    mem[8'h10] = 5;      mem[8'h11] = 8'h20;
    mem[8'h20] = 7;      mem[8'h21] = 8'h30;
    mem[8'h30] = 9;      mem[8'h31] = 8'h00;
    mem[8'h40] = 3;      mem[8'h41] = 8'h50;
    mem[8'h50] = 4;      mem[8'h51] = 8'h40;
    mem[8'h60] = 16'hFFF0; mem[8'h61] = 8'h70;
    mem[8'h70] = 16'h0020; mem[8'h71] = 8'h00;
    mem[8'h80] = 1;      mem[8'h81] = 8'h84;
    mem[8'h84] = 2;      mem[8'h85] = 8'h88;
    mem[8'h88] = 3;      mem[8'h89] = 8'h8C;
    mem[8'h8C] = 4;      mem[8'h8D] = 8'h00;
    mem[8'h90] = 16'h0030; mem[8'h91] = 8'hA0;
    mem[8'hA0] = 16'h0100; mem[8'hA1] = 8'hB0;
    mem[8'hB0] = 16'h0005; mem[8'hB1] = 8'h00;
    mem[8'hFF] = 2;      // next pointer lives at 0x00 (wrapped), which is 0
`ifdef LIST_WALK_SAT_EN
    exp_ovf = 16'hFFFF;
`else
    exp_ovf = 16'h0010;
`endif

    vecs[0]  = '{8'h10, 1'b0, 10, 16'd21,   3, 1'b0};
    vecs[1]  = '{8'h10, 1'b1, 10, 16'd9,    3, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1,  16'd0,    0, 1'b0};
    vecs[3]  = '{8'h40, 1'b0, 13, 16'd14,   4, 1'b1};
    vecs[4]  = '{8'h40, 1'b1, 13, 16'd4,    4, 1'b1};
    vecs[5]  = '{8'h60, 1'b0, 7,  exp_ovf,  2, 1'b0};
    vecs[6]  = '{8'h60, 1'b1, 7,  16'hFFF0, 2, 1'b0};
    vecs[7]  = '{8'h80, 1'b0, 13, 16'd10,   4, 1'b0};
    vecs[8]  = '{8'h90, 1'b1, 10, 16'h0100, 3, 1'b0};
    vecs[9]  = '{8'h90, 1'b0, 10, 16'h0135, 3, 1'b0};
    vecs[10] = '{8'hFF, 1'b0, 4,  16'd2,    1, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; head = '0;
    tick(); tick();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      walk(vecs[i].head, vecs[i].mode, cyc, rd_seen, addr_bad);
      chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_busy_in_fin", i), busy, 1);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_rd_seen", i), rd_seen, vecs[i].head != 0);
      chk($sformatf("v%0d_addr_busy_rules", i), addr_bad, 0);
      tick();
      chk($sformatf("v%0d_idle_busy", i), {busy, done}, 0);
      chk($sformatf("v%0d_held", i), {err, count, result}, {vecs[i].err, CW'(vecs[i].cnt), vecs[i].res});
    end

    // start held high for the whole walk: one done pulse only
    pulses = 0;
    start = 1'b1; head = 8'h10; mode = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) begin pulses++; start = 1'b0; end
    end
    start = 1'b0;
    chk("hold_start_pulses", pulses, 1);
    chk("hold_start_result", result, 21);

    // reset during ACC of node 2 (cycle 5), then a clean walk
    start = 1'b1; head = 8'h10; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    chk("pre_rst_in_acc", {mem_rd, mem_addr}, {1'b1, 8'h21});
    rst = 1'b1;
    tick();
    chk("midrst_outputs", {mem_rd, mem_addr, busy, done, err, result, count}, 0);
    rst = 1'b0;
    tick();
    walk(8'h10, 1'b1, cyc, rd_seen, addr_bad);
    chk("post_rst_cycle", cyc, 10);
    chk("post_rst_result", result, 9);
    chk("post_rst_count", count, 3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
